// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with mem_ready handshake, wait-state bus timeout
// and illegal-instruction trap. Selects are pure opcode/funct decode; enables follow the FSM.
module mc_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TMO_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] Mem2Reg,
    output logic [1:0] NPCSel,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMemRd  = 3'd3,
        StMemWr  = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam logic [TMO_W-1:0] TmoLast = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e           r_state, w_state_nxt;
    logic [TMO_W-1:0] r_wait, w_wait_nxt;
    logic             r_illegal, r_bus_err;

    logic w_rtype, w_addu, w_subu, w_slt, w_jr;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_supported, w_wait_st, w_tmo;

    always_comb begin
        w_rtype     = (opcode == 6'h00);
        w_addu      = w_rtype && (funct == 6'h21);
        w_subu      = w_rtype && (funct == 6'h23);
        w_slt       = w_rtype && (funct == 6'h2A);
        w_jr        = w_rtype && (funct == 6'h08);
        w_ori       = (opcode == 6'h0D);
        w_lui       = (opcode == 6'h0F);
        w_lw        = (opcode == 6'h23);
        w_sw        = (opcode == 6'h2B);
        w_beq       = (opcode == 6'h04);
        w_j         = (opcode == 6'h02);
        w_jal       = (opcode == 6'h03);
        w_supported = w_addu | w_subu | w_slt | w_jr | w_ori | w_lui |
                      w_lw | w_sw | w_beq | w_j | w_jal;
    end

    // Timeout fires in the cycle that would be the TIMEOUT-th consecutive stall.
    always_comb begin
        w_wait_st = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
        w_tmo     = (TIMEOUT != 0) && w_wait_st && !mem_ready && (r_wait == TmoLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StFetch;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_illegal <= r_illegal | ((r_state == StDecode) && !w_supported);
            r_bus_err <= r_bus_err | w_tmo;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StFetch: begin
                if (mem_ready)  w_state_nxt = StDecode;
                else if (w_tmo) w_state_nxt = StTrap;
            end
            StDecode: begin
                if (!w_supported)           w_state_nxt = StTrap;
                else if (w_j | w_jal | w_jr) w_state_nxt = StFetch;
                else                        w_state_nxt = StExec;
            end
            StExec: begin
                if (w_beq)     w_state_nxt = StFetch;
                else if (w_lw) w_state_nxt = StMemRd;
                else if (w_sw) w_state_nxt = StMemWr;
                else           w_state_nxt = StWb;
            end
            StMemRd: begin
                if (mem_ready)  w_state_nxt = StWb;
                else if (w_tmo) w_state_nxt = StTrap;
            end
            StMemWr: begin
                if (mem_ready)  w_state_nxt = StFetch;
                else if (w_tmo) w_state_nxt = StTrap;
            end
            StWb:    w_state_nxt = StFetch;
            StTrap:  w_state_nxt = StTrap;
            default: w_state_nxt = StFetch;
        endcase
        w_wait_nxt = (w_wait_st && !mem_ready && (w_state_nxt == r_state)) ?
                     r_wait + TMO_W'(1) : '0;
    end

    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RegWr   = 1'b0;
        MemWr   = 1'b0;
        RegDst  = w_jal ? 2'b10 : (w_rtype ? 2'b01 : 2'b00);
        ALUSrc  = w_ori | w_lui | w_lw | w_sw;
        Mem2Reg = w_jal ? 2'b10 : (w_lw ? 2'b01 : 2'b00);
        NPCSel  = w_beq ? 2'b01 : ((w_j | w_jal) ? 2'b10 : (w_jr ? 2'b11 : 2'b00));
        EXTOp   = w_lui ? 2'b10 : ((w_lw | w_sw | w_beq) ? 2'b01 : 2'b00);
        ALUOp   = (w_subu | w_beq) ? 3'b001 : (w_ori ? 3'b010 : (w_slt ? 3'b011 : 3'b000));
        unique case (r_state)
            StFetch: begin
                // Opcode still holds the previous instruction here; fetch is always PC+4.
                NPCSel = 2'b00;
                PCWr   = mem_ready;
                IRWr   = mem_ready;
            end
            StDecode: begin
                PCWr  = w_j | w_jal | w_jr;
                RegWr = w_jal;
            end
            StExec:  PCWr = w_beq & zero;
            StMemWr: MemWr = 1'b1;
            StWb:    RegWr = 1'b1;
            default: ;
        endcase
        if (reset) begin
            PCWr  = 1'b0;
            IRWr  = 1'b0;
            RegWr = 1'b0;
            MemWr = 1'b0;
        end
    end

    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: reset, R/lw/beq/j/jr/lui/sw/jal flows, timeout and traps.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, illegal, bus_err;
    logic [1:0] RegDst, Mem2Reg, NPCSel, EXTOp;
    logic [2:0] ALUOp, state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int c0;

    mc_controller #(.TIMEOUT(16), .TMO_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .NPCSel(NPCSel),
        .EXTOp(EXTOp), .ALUOp(ALUOp), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h21;
        cyc(); cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pcwr", 32'(PCWr), 32'd0);
        chk("rst_irwr", 32'(IRWr), 32'd0);
        chk("rst_regwr", 32'(RegWr), 32'd0);
        chk("rst_memwr", 32'(MemWr), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);
        reset = 1'b0; settle();
        chk("fetch_irwr", 32'(IRWr), 32'd1);
        chk("fetch_pcwr", 32'(PCWr), 32'd1);
        chk("fetch_npc", 32'(NPCSel), 32'd0);

        // addu
        cyc();
        chk("addu_dec", 32'(state), 32'd1);
        chk("addu_dec_regwr", 32'(RegWr), 32'd0);
        cyc();
        chk("addu_exec", 32'(state), 32'd2);
        chk("addu_aluop", 32'(ALUOp), 32'd0);
        cyc();
        chk("addu_wb", 32'(state), 32'd5);
        chk("addu_wb_regwr", 32'(RegWr), 32'd1);
        chk("addu_regdst", 32'(RegDst), 32'd1);
        chk("addu_alusrc", 32'(ALUSrc), 32'd0);
        chk("addu_m2r", 32'(Mem2Reg), 32'd0);
        cyc();
        chk("addu_back", 32'(state), 32'd0);
        chk("addu_back_regwr", 32'(RegWr), 32'd0);

        // lw with three stall cycles in MEMRD
        opcode = 6'h23; settle();
        c0 = cyc_n;
        cyc(); cyc();
        chk("lw_exec", 32'(state), 32'd2);
        chk("lw_ext", 32'(EXTOp), 32'd1);
        chk("lw_alusrc", 32'(ALUSrc), 32'd1);
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_memrd_hold", 32'(state), 32'd3);
            chk("lw_memrd_regwr", 32'(RegWr), 32'd0);
            cyc();
        end
        chk("lw_memrd_last", 32'(state), 32'd3);
        mem_ready = 1'b1;
        cyc();
        chk("lw_wb", 32'(state), 32'd5);
        chk("lw_wb_regwr", 32'(RegWr), 32'd1);
        chk("lw_m2r", 32'(Mem2Reg), 32'd1);
        chk("lw_regdst", 32'(RegDst), 32'd0);
        cyc();
        chk("lw_back", 32'(state), 32'd0);
        chk("lw_latency", 32'(cyc_n - c0), 32'd8);

        // beq taken then not taken
        opcode = 6'h04; zero = 1'b1;
        cyc(); cyc();
        chk("beq1_exec", 32'(state), 32'd2);
        chk("beq1_pcwr", 32'(PCWr), 32'd1);
        chk("beq1_npc", 32'(NPCSel), 32'd1);
        chk("beq1_aluop", 32'(ALUOp), 32'd1);
        chk("beq1_ext", 32'(EXTOp), 32'd1);
        cyc();
        chk("beq1_back", 32'(state), 32'd0);
        zero = 1'b0;
        cyc(); cyc();
        chk("beq0_exec", 32'(state), 32'd2);
        chk("beq0_pcwr", 32'(PCWr), 32'd0);
        chk("beq0_npc", 32'(NPCSel), 32'd1);
        cyc();
        chk("beq0_back", 32'(state), 32'd0);

        // j and jr
        opcode = 6'h02;
        cyc();
        chk("j_dec", 32'(state), 32'd1);
        chk("j_pcwr", 32'(PCWr), 32'd1);
        chk("j_npc", 32'(NPCSel), 32'd2);
        chk("j_regwr", 32'(RegWr), 32'd0);
        cyc();
        chk("j_back", 32'(state), 32'd0);
        opcode = 6'h00; funct = 6'h08;
        cyc();
        chk("jr_pcwr", 32'(PCWr), 32'd1);
        chk("jr_npc", 32'(NPCSel), 32'd3);
        cyc();
        chk("jr_back", 32'(state), 32'd0);

        // lui
        opcode = 6'h0F;
        cyc();
        chk("lui_ext", 32'(EXTOp), 32'd2);
        chk("lui_alusrc", 32'(ALUSrc), 32'd1);
        cyc(); cyc();
        chk("lui_wb_regwr", 32'(RegWr), 32'd1);
        chk("lui_regdst", 32'(RegDst), 32'd0);
        cyc();
        chk("lui_back", 32'(state), 32'd0);

        // sw: mem_ready arrives in the 16th stall cycle, completing instead of trapping
        opcode = 6'h2B;
        cyc(); cyc();
        chk("sw_exec_alusrc", 32'(ALUSrc), 32'd1);
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 15; i++) begin
            chk("sw_hold_memwr", 32'(MemWr), 32'd1);
            cyc();
        end
        mem_ready = 1'b1; settle();
        chk("sw_edge_state", 32'(state), 32'd4);
        chk("sw_edge_memwr", 32'(MemWr), 32'd1);
        cyc();
        chk("sw_edge_back", 32'(state), 32'd0);
        chk("sw_edge_buserr", 32'(bus_err), 32'd0);

        // sw with dead bus for 16 cycles -> bus trap
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("tmo_state", 32'(state), 32'd4);
            chk("tmo_memwr", 32'(MemWr), 32'd1);
            cyc();
        end
        chk("tmo_trap", 32'(state), 32'd6);
        chk("tmo_buserr", 32'(bus_err), 32'd1);
        chk("tmo_memwr_off", 32'(MemWr), 32'd0);
        mem_ready = 1'b1;
        cyc();
        chk("trap_absorb", 32'(state), 32'd6);
        chk("trap_pcwr", 32'(PCWr), 32'd0);
        chk("trap_irwr", 32'(IRWr), 32'd0);
        chk("trap_buserr_sticky", 32'(bus_err), 32'd1);

        reset = 1'b1;
        cyc();
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_buserr", 32'(bus_err), 32'd0);
        reset = 1'b0;

        // reset asserted while MEMWR is stalled
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        chk("midrst_memwr_pre", 32'(MemWr), 32'd1);
        reset = 1'b1; settle();
        chk("midrst_memwr", 32'(MemWr), 32'd0);
        cyc();
        chk("midrst_state", 32'(state), 32'd0);
        reset = 1'b0; mem_ready = 1'b1;

        // illegal opcode
        opcode = 6'h3F;
        cyc();
        chk("ill_dec", 32'(state), 32'd1);
        chk("ill_pre", 32'(illegal), 32'd0);
        chk("ill_pcwr", 32'(PCWr), 32'd0);
        cyc();
        chk("ill_trap", 32'(state), 32'd6);
        chk("ill_flag", 32'(illegal), 32'd1);
        opcode = 6'h00; funct = 6'h21;
        cyc(); cyc();
        chk("ill_absorb", 32'(state), 32'd6);
        chk("ill_sticky", 32'(illegal), 32'd1);
        chk("ill_regwr", 32'(RegWr), 32'd0);
        reset = 1'b1;
        cyc();
        chk("ill_rst_clear", 32'(illegal), 32'd0);
        reset = 1'b0;

        // jal
        opcode = 6'h03;
        cyc();
        chk("jal_dec", 32'(state), 32'd1);
        chk("jal_regwr", 32'(RegWr), 32'd1);
        chk("jal_pcwr", 32'(PCWr), 32'd1);
        chk("jal_regdst", 32'(RegDst), 32'd2);
        chk("jal_m2r", 32'(Mem2Reg), 32'd2);
        chk("jal_npc", 32'(NPCSel), 32'd2);
        cyc();
        chk("jal_back", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
